// File: rtl/col_parity_func.sv
// Column-parity (theta-style) mixing over a 5x5x64 bit matrix held in an
// external slice memory. The first pass collects the column parities of every
// slice. The second pass re-reads each slice and emits the mixed result, one
// write_enable pulse per slice, from z=0 to z=63.
module col_parity_func (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [5:0]  cnt_value,
  input  logic [24:0] line_in,
  output logic        write_enable,
  output logic [24:0] write_value,
  output logic        donee
);

  typedef enum logic [2:0] {
    IDLE,
    PARITY,
    WR_SETUP,
    WR_PULSE,
    DONE
  } state_t;

  state_t      state;
  logic [4:0]  par_mem [64];
  logic [4:0]  col_par;
  logic [4:0]  prev_par;
  logic [4:0]  d_vec;
  logic [24:0] d_exp;

  // Column parities of the slice currently on line_in.
  always_comb begin
    col_par = '0;
    for (int unsigned y = 0; y < 5; y++) begin
      for (int unsigned x = 0; x < 5; x++) begin
        col_par[x] = col_par[x] ^ line_in[5*y + x];
      end
    end
  end

  // Theta column term D[x][z], broadcast across all rows of the slice.
  // The previous slice wraps naturally: z=0 reads entry 63 through 6-bit arithmetic.
  always_comb begin
    prev_par = par_mem[cnt_value - 6'd1];
    d_vec    = '0;
    d_exp    = '0;
    for (int unsigned x = 0; x < 5; x++) begin
      d_vec[x] = col_par[(x + 4) % 5] ^ prev_par[(x + 1) % 5];
    end
    for (int unsigned y = 0; y < 5; y++) begin
      for (int unsigned x = 0; x < 5; x++) begin
        d_exp[5*y + x] = d_vec[x];
      end
    end
  end

  // Parity store: written once per slice during the parity pass; needs no reset.
  always_ff @(posedge clk) begin
    if (state == PARITY) begin
      par_mem[cnt_value] <= col_par;
    end
  end

  // Control FSM with registered outputs.
  // write_value is captured at the end of WR_SETUP. write_enable is raised
  // one edge later, at the end of WR_PULSE, so the data has already been
  // stable for a full cycle when the pulse rises. The pulse then lasts through
  // the next WR_SETUP cycle, or the first DONE cycle for the last slice, and
  // write_value only changes at the end of that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt_value    <= '0;
      write_enable <= 1'b0;
      write_value  <= '0;
      donee        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt_value    <= '0;
          write_enable <= 1'b0;
          donee        <= 1'b0;
          if (start) begin
            state <= PARITY;
          end
        end
        PARITY: begin
          if (cnt_value == 6'd63) begin
            cnt_value <= '0;
            state     <= WR_SETUP;
          end else begin
            cnt_value <= cnt_value + 6'd1;
          end
        end
        WR_SETUP: begin
          write_value  <= line_in ^ d_exp;
          write_enable <= 1'b0;
          state        <= WR_PULSE;
        end
        WR_PULSE: begin
          write_enable <= 1'b1;
          if (cnt_value == 6'd63) begin
            state <= DONE;
          end else begin
            cnt_value <= cnt_value + 6'd1;
            state     <= WR_SETUP;
          end
        end
        DONE: begin
          write_enable <= 1'b0;
          if (donee && !start) begin
            donee     <= 1'b0;
            cnt_value <= '0;
            state     <= IDLE;
          end else begin
            donee <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_col_parity_func.sv
// Scoreboard bench for col_parity_func. It models the slice memory and
// computes the expected output slices bit by bit from the theta equations.
module tb_col_parity_func;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  cnt_value;
  logic [24:0] line_in;
  logic        write_enable;
  logic [24:0] write_value;
  logic        donee;

  logic [24:0] mem [64];
  logic [24:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign line_in = mem[cnt_value];

  col_parity_func dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cnt_value    (cnt_value),
    .line_in      (line_in),
    .write_enable (write_enable),
    .write_value  (write_value),
    .donee        (donee)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: push the 64 expected output slices in the order z = 0..63.
  task automatic push_expected();
    logic [4:0]  c [64];
    logic [24:0] s;
    logic        d;
    exp_q.delete();
    for (int z = 0; z < 64; z++) begin
      s = mem[z];
      for (int x = 0; x < 5; x++) begin
        c[z][x] = s[x] ^ s[5+x] ^ s[10+x] ^ s[15+x] ^ s[20+x];
      end
    end
    for (int z = 0; z < 64; z++) begin
      s = mem[z];
      for (int x = 0; x < 5; x++) begin
        d = c[z][(x+4)%5] ^ c[(z+63)%64][(x+1)%5];
        for (int y = 0; y < 5; y++) s[5*y+x] = s[5*y+x] ^ d;
      end
      exp_q.push_back(s);
    end
  endtask

  // Runs one pass with start held high for `budget` cycles.
  // drop_at > 0 releases start at that cycle; rst_at > 0 aborts the run at that cycle.
  task automatic run_pass(input int budget, input int drop_at, input int rst_at);
    int pulses = 0, rises = 0, last_n = 0, n = 0;
    logic prev_we = 1'b0, prev_done = 1'b0;
    logic [24:0] prev_wv = '0, exp_v;
    push_expected();
    start = 1'b1;
    for (n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (n == drop_at) start = 1'b0;
      if (n <= 64) check_eq($sformatf("par_cnt%0d", n), {26'd0, cnt_value}, n - 1);
      if (rst_at > 0 && n == rst_at) begin
        #2 rst = 1'b1;
        #1;
        check_eq("abort_cnt", {26'd0, cnt_value}, 0);
        check_eq("abort_we", {31'd0, write_enable}, 0);
        check_eq("abort_wv", {7'd0, write_value}, 0);
        check_eq("abort_done", {31'd0, donee}, 0);
        @(negedge clk);
        check_eq("abort_no_we", {31'd0, write_enable}, 0);
        rst = 1'b0;
        exp_q.delete();
        return;
      end
      if (write_enable) begin
        check_eq("we_gap", {31'd0, prev_we}, 0);
        check_eq("wv_stable", {7'd0, write_value}, {7'd0, prev_wv});
        if (pulses == 0) check_eq("lat_first", n - 1, 66);
        else check_eq("pulse_period", n - last_n, 2);
        if (exp_q.size() == 0) begin
          check_eq("extra_pulse", pulses, 63);
        end else begin
          exp_v = exp_q.pop_front();
          check_eq($sformatf("slice%0d", pulses), {7'd0, write_value}, {7'd0, exp_v});
        end
        pulses++;
        last_n = n;
      end
      if (donee && !prev_done) begin
        rises++;
        check_eq("done_lat", n - last_n, 1);
      end
      prev_we   = write_enable;
      prev_wv   = write_value;
      prev_done = donee;
    end
    check_eq("pulse_count", pulses, 64);
    check_eq("done_rises", rises, 1);
    check_eq("q_empty", exp_q.size(), 0);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("idle_done", {31'd0, donee}, 0);
    check_eq("idle_cnt", {26'd0, cnt_value}, 0);
  endtask

  task automatic fill(input logic [24:0] v);
    for (int z = 0; z < 64; z++) mem[z] = v;
  endtask

  task automatic fill_random();
    for (int z = 0; z < 64; z++) mem[z] = 25'($urandom);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    fill('0);
    #1;
    check_eq("rst_cnt", {26'd0, cnt_value}, 0);
    check_eq("rst_we", {31'd0, write_enable}, 0);
    check_eq("rst_wv", {7'd0, write_value}, 0);
    check_eq("rst_done", {31'd0, donee}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Start held high long after completion: exactly one run.
    fill('0);
    run_pass(1500, 0, 0);

    fill('1);
    run_pass(260, 0, 0);

    fill('0);
    mem[0] = 25'd1;
    run_pass(260, 0, 0);

    fill('0);
    mem[63] = 25'd1;
    run_pass(260, 0, 0);

    // Releasing start mid-run is ignored.
    fill_random();
    run_pass(260, 10, 0);

    // Reset during the write phase, then a fresh run with start still high.
    fill_random();
    run_pass(260, 0, 150);
    run_pass(260, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
